dnn_acc_sequencer: RTL and testbench
====================================

# dnn_acc_sequencer

Job sequencer for the DNN inference accelerator. It accepts inference jobs on a valid/ready port and drives the accelerator's ap_ctrl_hs handshake (start/ready/done). When a job finishes it scans the accelerator's output score memory and reduces it to an argmax label, then returns one result per job on a valid/ready port. It sits between the host-side job source and the accelerator block, and replaces ad-hoc start/readback logic in the top-level test driver.

## Interface

Parameters:
- NUM_LBLS, 10: number of output scores (labels) scanned per job; range 1..32.
- LBL_W, 5: label index width; must satisfy 2^LBL_W >= NUM_LBLS.
- ID_W, 8: job identifier width.
- TIMEOUT, 65535: maximum cycles from start assertion to ap_done before the job is aborted.
- GAP_CYCLES, 100: idle cycles inserted after each result handshake before the next job is accepted; 0 allowed.

Ports (clock and reset first):
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  reset, asynchronous, active-high (aresetn=1 resets).
- job_valid  in  1  job request valid.
- job_ready  out  1  job accepted when job_valid && job_ready.
- job_id  in  ID_W  job identifier, captured on accept.
- acc_start  out  1  ap_start to the accelerator.
- acc_ready  in  1  ap_ready from the accelerator.
- acc_done  in  1  ap_done from the accelerator.
- acc_idle  in  1  ap_idle from the accelerator; accept is gated on it.
- rd_en  out  1  output-memory read enable.
- rd_addr  out  32  output-memory byte address; score i is at i*4.
- rd_dout  in  32  read data, valid 1 cycle after rd_en; score = signed rd_dout[15:0].
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_id  out  ID_W  job_id of the result.
- res_lbl  out  LBL_W  argmax index.
- res_max  out  16  signed maximum score.
- res_err  out  1  1 = job aborted by timeout.
- busy  out  1  high in every state except IDLE.
- jobs_done  out  16  count of result handshakes; wraps at 2^16.

## Operation

- States: IDLE, START, WAIT_DONE, SCAN, RESULT, GAP.
- IDLE:
  - job_ready = acc_idle.
  - On accept, capture job_id, clear the timeout counter, and go to START.
- START:
  - acc_start=1, held until acc_ready is sampled high.
  - acc_ready && acc_done in the same cycle goes to SCAN; acc_ready alone goes to WAIT_DONE.
- WAIT_DONE:
  - acc_start=0.
  - acc_done goes to SCAN.
- Timeout:
  - The counter runs in START and WAIT_DONE.
  - When it reaches TIMEOUT-1 without acc_done, the block sets res_err=1, res_lbl=0 and res_max=0, drops acc_start and goes to RESULT.
  - If acc_done arrives in the same cycle the counter hits TIMEOUT-1, done wins and the block goes to SCAN.
- SCAN:
  - rd_en=1 for NUM_LBLS consecutive cycles with rd_addr = i*4, i = 0..NUM_LBLS-1.
  - Score 0 initialises max and index. Each later score replaces them only if strictly greater (signed 16-bit compare), so ties keep the lowest index.
  - After the last score is compared, go to RESULT.
- RESULT:
  - res_valid=1 and the res_* fields stay stable until res_ready.
  - On the handshake, jobs_done increments and the block goes to GAP (or straight to IDLE if GAP_CYCLES=0).
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Outputs outside their states: rd_en=0 and rd_addr=0 outside SCAN; acc_start=0 outside START.
- acc_done seen in IDLE, SCAN, RESULT or GAP is ignored.
- Reset mid-operation returns to IDLE immediately and drops acc_start, rd_en and res_valid. Any in-flight accelerator run is abandoned, and the next accept waits for acc_idle.

## Timing

- Reset values:
  - state=IDLE; acc_start=0, rd_en=0, rd_addr=0.
  - res_valid=0, res_id=0, res_lbl=0, res_max=0, res_err=0.
  - busy=0, jobs_done=0, counters=0.
  - job_ready follows acc_idle.
- Job accepted at cycle a: acc_start=1 from cycle a+1.
- acc_done sampled at cycle d: SCAN occupies d+1..d+NUM_LBLS (rd_en high), the final compare registers at d+NUM_LBLS+1, and res_valid rises at d+NUM_LBLS+2.
- Timeout: res_valid rises TIMEOUT+1 cycles after acc_start first rises.
- Result handshake at cycle r: job_ready may next be high at r+GAP_CYCLES+1.
- All outputs are registered except job_ready (= state==IDLE && acc_idle).

## Test plan

- Single job: job_id=0x5A, acc_ready 3 cycles after start, acc_done 20 cycles later, scores {3,-7,12,5,12,0,1,2,-1,4} -> res_lbl=2, res_max=12, res_err=0, res_id=0x5A, res_valid exactly 12 cycles after done.
- All-negative scores {-5,-3,-9,-3,-8,-6,-4,-7,-10,-20} -> res_lbl=1, res_max=-3 (tie keeps lowest index).
- acc_ready and acc_done asserted in the same cycle as the first acc_start cycle -> no WAIT_DONE visit, scan starts the next cycle, correct label.
- acc_done never asserted, TIMEOUT=50 -> res_err=1, res_lbl=0, acc_start low, res_valid at cycle 51 after start; the next job then runs normally.
- Back-to-back jobs with res_ready held low 7 cycles, GAP_CYCLES=4 -> res_* stable while stalled, jobs_done 0->1->2, second accept no earlier than 5 cycles after the first handshake.
- aresetn pulsed during SCAN -> rd_en=0 and state IDLE in the same cycle, no result emitted, jobs_done unchanged at 0.

Source files
------------

// File: rtl/dnn_acc_sequencer_if.sv
// Bundle of the job, accelerator-control, score-readback and result signals
// around the DNN job sequencer.
interface dnn_acc_sequencer_if #(
    parameter int ID_W  = 8,
    parameter int LBL_W = 5
);
    logic             job_valid;
    logic             job_ready;
    logic [ID_W-1:0]  job_id;
    logic             acc_start;
    logic             acc_ready;
    logic             acc_done;
    logic             acc_idle;
    logic             rd_en;
    logic [31:0]      rd_addr;
    logic [31:0]      rd_dout;
    logic             res_valid;
    logic             res_ready;
    logic [ID_W-1:0]  res_id;
    logic [LBL_W-1:0] res_lbl;
    logic [15:0]      res_max;
    logic             res_err;
    logic             busy;
    logic [15:0]      jobs_done;

    modport master (
        input  job_valid, job_id, acc_ready, acc_done, acc_idle, rd_dout, res_ready,
        output job_ready, acc_start, rd_en, rd_addr, res_valid, res_id, res_lbl,
               res_max, res_err, busy, jobs_done
    );

    modport slave (
        output job_valid, job_id, acc_ready, acc_done, acc_idle, rd_dout, res_ready,
        input  job_ready, acc_start, rd_en, rd_addr, res_valid, res_id, res_lbl,
               res_max, res_err, busy, jobs_done
    );
endinterface

// File: rtl/dnn_acc_sequencer.sv
// Job sequencer: launches the accelerator over ap_ctrl_hs, reduces its score
// memory to an argmax label and returns one result per job.
//
// state     | meaning
// IDLE      | waiting for a job while the accelerator reports idle
// START     | acc_start held until acc_ready
// WAIT_DONE | accelerator running, waiting for acc_done
// SCAN      | streaming score reads, running argmax
// RESULT    | last compare settles, then result held until res_ready
// GAP       | idle spacing before the next job is accepted
module dnn_acc_sequencer #(
    parameter int NUM_LBLS   = 10,
    parameter int LBL_W      = 5,
    parameter int ID_W       = 8,
    parameter int TIMEOUT    = 65535,
    parameter int GAP_CYCLES = 100
) (
    input logic aclk,
    input logic aresetn,
    dnn_acc_sequencer_if.master bus
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LBL_W-1:0] LAST_IDX = LBL_W'(NUM_LBLS - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, SCAN, RESULT, GAP} state_t;

    state_t            state;
    logic [TO_W-1:0]   to_cnt;
    logic [GP_W-1:0]   gap_cnt;
    logic [LBL_W-1:0]  rd_idx;
    logic [LBL_W-1:0]  cmp_idx;
    logic              cmp_vld;
    logic signed [15:0] score;
    logic              to_hit;
    logic              go_scan;
    logic              take;
    logic              unused_hi;

    assign score     = $signed(bus.rd_dout[15:0]);
    assign unused_hi = ^bus.rd_dout[31:16];
    assign to_hit    = (to_cnt == '0);
    assign go_scan   = bus.acc_done && ((state == WAIT_DONE) || (state == START && bus.acc_ready));
    // Score 0 always seeds the running max; later scores must be strictly greater.
    assign take      = cmp_vld && ((cmp_idx == '0) || (score > $signed(bus.res_max)));

    assign bus.job_ready = (state == IDLE) && bus.acc_idle;

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state         <= IDLE;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            rd_idx        <= '0;
            cmp_idx       <= '0;
            cmp_vld       <= 1'b0;
            bus.acc_start <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_lbl   <= '0;
            bus.res_max   <= '0;
            bus.res_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.jobs_done <= '0;
        end else begin
            // read data returns one cycle after the request
            cmp_vld <= bus.rd_en;
            cmp_idx <= rd_idx;
            if (take) begin
                bus.res_max <= score;
                bus.res_lbl <= cmp_idx;
            end

            case (state)
                IDLE: begin
                    if (bus.job_valid && bus.acc_idle) begin
                        bus.res_id    <= bus.job_id;
                        bus.res_err   <= 1'b0;
                        to_cnt        <= TO_W'(TIMEOUT - 1);
                        bus.acc_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= START;
                    end
                end
                START, WAIT_DONE: begin
                    if (go_scan) begin
                        bus.acc_start <= 1'b0;
                        bus.rd_en     <= 1'b1;
                        bus.rd_addr   <= '0;
                        rd_idx        <= '0;
                        state         <= SCAN;
                    end else if (to_hit) begin
                        bus.acc_start <= 1'b0;
                        bus.res_err   <= 1'b1;
                        bus.res_lbl   <= '0;
                        bus.res_max   <= '0;
                        state         <= RESULT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                        if (state == START && bus.acc_ready) begin
                            bus.acc_start <= 1'b0;
                            state         <= WAIT_DONE;
                        end
                    end
                end
                SCAN: begin
                    if (rd_idx == LAST_IDX) begin
                        bus.rd_en   <= 1'b0;
                        bus.rd_addr <= '0;
                        state       <= RESULT;
                    end else begin
                        rd_idx      <= rd_idx + 1'b1;
                        bus.rd_addr <= 32'(rd_idx + 1'b1) << 2;
                    end
                end
                RESULT: begin
                    if (!bus.res_valid) begin
                        bus.res_valid <= 1'b1;
                    end else if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.jobs_done <= bus.jobs_done + 1'b1;
                        if (GAP_CYCLES == 0) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            gap_cnt <= GP_W'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dnn_acc_sequencer.sv
// Randomised bench for dnn_acc_sequencer with an argmax/timing reference model.
module tb_dnn_acc_sequencer;
    localparam int NUM   = 10;
    localparam int LBL_W = 5;
    localparam int ID_W  = 8;
    localparam int TMO   = 50;
    localparam int GAP   = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    dnn_acc_sequencer_if #(.ID_W(ID_W), .LBL_W(LBL_W)) bus ();

    dnn_acc_sequencer #(
        .NUM_LBLS(NUM), .LBL_W(LBL_W), .ID_W(ID_W), .TIMEOUT(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    logic signed [15:0] sc [NUM];
    int n_chk    = 0;
    int n_err    = 0;
    int exp_jobs = 0;

    // score memory: upper half of each word is junk the DUT must ignore
    always @(posedge aclk) begin
        bus.rd_dout[31:16] <= 16'($urandom);
        bus.rd_dout[15:0]  <= (bus.rd_en && bus.rd_addr < 32'(NUM * 4)) ?
                              sc[bus.rd_addr[5:2]] : 16'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_lbl();
        int best = 0;
        for (int i = 1; i < NUM; i++)
            if (sc[i] > sc[best]) best = i;
        return best;
    endfunction

    task automatic run_job(input logic [ID_W-1:0] id, input int rdy, input int dn,
                           input bit hang, input int stall, input int rst_at);
        int dk, r_off, w, lbl;
        logic exp_st, exp_rd;
        logic [31:0] exp_ad;
        logic [63:0] exp_res;
        dk    = rdy + dn;
        lbl   = ref_lbl();
        r_off = hang ? TMO + 1 : dk + NUM + 2;
        w = 0;
        while (!bus.job_ready && w < 300) begin
            @(negedge aclk);
            w++;
        end
        check("job_ready", 64'(bus.job_ready), 64'(1));
        bus.job_valid = 1'b1;
        bus.job_id    = id;
        @(negedge aclk);
        bus.job_valid = 1'b0;
        bus.job_id    = ID_W'($urandom);
        check("busy", 64'(bus.busy), 64'(1));
        for (int k = 0; k < r_off; k++) begin
            exp_st = (k <= rdy) && (k <= TMO - 1);
            exp_rd = !hang && (k > dk) && (k <= dk + NUM);
            exp_ad = exp_rd ? 32'((k - dk - 1) * 4) : 32'd0;
            check("seq", 64'({bus.acc_start, bus.rd_en, bus.rd_addr, bus.res_valid}),
                  64'({exp_st, exp_rd, exp_ad, 1'b0}));
            if (k == rst_at) begin
                aresetn      = 1'b1;
                bus.acc_idle = 1'b0;
                #1;
                check("rst_out", 64'({bus.acc_start, bus.rd_en, bus.rd_addr, bus.res_valid,
                                      bus.busy, bus.jobs_done, bus.job_ready}), 64'(0));
                exp_jobs      = 0;
                bus.job_valid = 1'b1;
                bus.acc_ready = 1'b0;
                bus.acc_done  = 1'b0;
                repeat (2) @(negedge aclk);
                aresetn = 1'b0;
                repeat (3) begin
                    @(negedge aclk);
                    check("idle_gate", 64'({bus.job_ready, bus.busy, bus.res_valid, bus.acc_start}),
                          64'(0));
                end
                bus.job_valid = 1'b0;
                bus.acc_idle  = 1'b1;
                #1;
                check("idle_release", 64'(bus.job_ready), 64'(1));
                return;
            end
            bus.acc_ready = (k == rdy);
            bus.acc_done  = !hang && ((k == dk) || (k > dk && $urandom_range(3) == 0));
            @(negedge aclk);
        end
        bus.acc_ready = 1'b0;
        exp_res = 64'({1'b1, hang, id, hang ? LBL_W'(0) : LBL_W'(lbl), hang ? 16'd0 : sc[lbl]});
        for (int j = 0; j <= stall; j++) begin
            check("res", 64'({bus.res_valid, bus.res_err, bus.res_id, bus.res_lbl, bus.res_max}),
                  exp_res);
            bus.acc_done  = !hang && ($urandom_range(1) == 1);
            bus.res_ready = (j == stall);
            @(negedge aclk);
        end
        bus.res_ready = 1'b0;
        bus.acc_done  = 1'b0;
        exp_jobs++;
        check("handshake", 64'({bus.res_valid, bus.jobs_done}), 64'({1'b0, 16'(exp_jobs)}));
        bus.job_valid = 1'b1;
        for (int g = 1; g <= GAP; g++) begin
            check("gap", 64'({bus.job_ready, bus.busy}), 64'({1'b0, 1'b1}));
            @(negedge aclk);
        end
        bus.job_valid = 1'b0;
        check("gap_end", 64'({bus.job_ready, bus.busy}), 64'({1'b1, 1'b0}));
    endtask

    task automatic rand_scores();
        bit narrow;
        narrow = ($urandom_range(1) == 1);
        for (int i = 0; i < NUM; i++)
            sc[i] = narrow ? $signed(16'($urandom_range(6))) - 16'sd3 : $signed(16'($urandom));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.job_valid = 1'b0;
        bus.job_id    = '0;
        bus.acc_ready = 1'b0;
        bus.acc_done  = 1'b0;
        bus.acc_idle  = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge aclk);
        check("reset_vals", 64'({bus.acc_start, bus.rd_en, bus.rd_addr, bus.res_valid, bus.res_id,
                                 bus.res_lbl, bus.res_max, bus.res_err, bus.busy, bus.jobs_done,
                                 bus.job_ready}), 64'(0));
        bus.acc_idle = 1'b1;
        #1;
        check("reset_ready", 64'(bus.job_ready), 64'(1));
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);

        sc = '{16'sd3, -16'sd7, 16'sd12, 16'sd5, 16'sd12, 16'sd0, 16'sd1, 16'sd2, -16'sd1, 16'sd4};
        run_job(8'h5A, 3, 20, 1'b0, 0, -1);
        sc = '{-16'sd5, -16'sd3, -16'sd9, -16'sd3, -16'sd8, -16'sd6, -16'sd4, -16'sd7,
               -16'sd10, -16'sd20};
        run_job(8'hC3, 1, 4, 1'b0, 7, -1);
        rand_scores();
        run_job(8'h11, 0, 0, 1'b0, 1, -1);
        run_job(8'h22, 2, 0, 1'b1, 2, -1);
        rand_scores();
        run_job(8'h33, 4, 6, 1'b0, 0, -1);
        run_job(8'h44, 1000, 0, 1'b1, 0, -1);
        rand_scores();
        run_job(8'h55, 2, TMO - 3, 1'b0, 0, -1);
        rand_scores();
        run_job(8'h66, 1, 3, 1'b0, 0, 8);
        run_job(8'h77, 2, 5, 1'b0, 0, -1);
        for (int n = 0; n < 20; n++) begin
            rand_scores();
            run_job(ID_W'($urandom), $urandom_range(5), $urandom_range(15), 1'b0,
                    $urandom_range(3), -1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
